// File: rtl/scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// scan_mux_pkg
// Shared definitions for the scanning multiplexer.
//   MODE_MANUAL / MODE_SINGLE / MODE_CONT : encodings of the 2-bit mode input
//                                           (2'b11 behaves like manual)
//   state_t                               : sequencer state (IDLE, SCAN)
// ---------------------------------------------------------------------------
package scan_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage : scan_mux_pkg

// File: rtl/scan_next_ch.sv
// ---------------------------------------------------------------------------
// scan_next_ch
// Combinational channel finder used by the scan sequencer.
// Ports:
//   i_mask  : channel enable mask, bit i = channel i
//   i_cur   : current channel index (search starts strictly above it)
//   i_incl  : 1 = ignore i_cur and return the lowest set bit overall
//   o_ch    : next enabled channel; when nothing lies above i_cur this is
//             the lowest enabled channel (wrap target)
//   o_wrap  : no enabled channel above i_cur, but the mask is nonzero
//   o_none  : mask is all zero
// ---------------------------------------------------------------------------
module scan_next_ch
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_mask,
    input  logic [SEL_W-1:0]    i_cur,
    input  logic                i_incl,
    output logic [SEL_W-1:0]    o_ch,
    output logic                o_wrap,
    output logic                o_none
);

    logic [SEL_W-1:0] w_aboveCh;
    logic             w_aboveFound;
    logic [SEL_W-1:0] w_lowCh;
    logic             w_lowFound;

    // Walking from the top bit down and overwriting on every hit leaves
    // the lowest qualifying channel in each result.
    always_comb begin
        w_aboveCh    = '0;
        w_aboveFound = 1'b0;
        w_lowCh      = '0;
        w_lowFound   = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lowCh    = SEL_W'(i);
                w_lowFound = 1'b1;
                if (i_incl || (i > int'(i_cur))) begin
                    w_aboveCh    = SEL_W'(i);
                    w_aboveFound = 1'b1;
                end
            end
        end
    end

    assign o_ch   = w_aboveFound ? w_aboveCh : w_lowCh;
    assign o_wrap = !w_aboveFound && w_lowFound;
    assign o_none = !w_lowFound;

endmodule : scan_next_ch

// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
// Registered N-channel multi-bit multiplexer with valid/ready output and a
// built-in channel sequencer (manual select, single scan, continuous scan).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   mode      : 00 manual, 01 single scan, 10 continuous scan, 11 manual
//   sel       : manual channel index (values >= CHANNELS give y = 0)
//   din       : packed channels, channel i at [i*WIDTH +: WIDTH]
//   en_mask   : channels visited by a scan
//   start     : scan start pulse (scan modes, idle only)
//   stop      : end a continuous scan after the next accept (sticky)
//   y, y_ch   : registered data and its channel index
//   y_valid   : y/y_ch valid; accepted by y_ready at a clock edge
//   y_ready   : consumer ready
//   busy      : scan in progress
//   done      : one-cycle pulse after a scan completes
// ---------------------------------------------------------------------------
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      start,
    input  logic                      stop,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic                      busy,
    output logic                      done
);

    state_t                r_state;
    logic [WIDTH-1:0]      r_y;
    logic [SEL_W-1:0]      r_yCh;
    logic                  r_yValid;
    logic                  r_done;
    logic [CHANNELS-1:0]   r_mask;
    logic                  r_cont;
    logic                  r_stop;

    state_t                w_stateNxt;
    logic [WIDTH-1:0]      w_yNxt;
    logic [SEL_W-1:0]      w_yChNxt;
    logic                  w_yValidNxt;
    logic                  w_doneNxt;
    logic [CHANNELS-1:0]   w_maskNxt;
    logic                  w_contNxt;
    logic                  w_stopNxt;

    logic                  w_slotFree;
    logic                  w_accept;
    logic                  w_scanMode;
    logic                  w_scanReq;
    logic [CHANNELS-1:0]   w_findMask;
    logic                  w_findIncl;
    logic [SEL_W-1:0]      w_findCh;
    logic                  w_findWrap;
    logic                  w_findNone;
    logic [SEL_W-1:0]      w_loadCh;
    logic [WIDTH-1:0]      w_loadData;

    // Out-of-range indices match no channel and therefore return zero.
    function automatic logic [WIDTH-1:0] pickData(
        input logic [CHANNELS*WIDTH-1:0] data,
        input logic [SEL_W-1:0]          ch
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == SEL_W'(i)) begin
                res = data[i*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    assign w_slotFree = !r_yValid || y_ready;
    assign w_accept   = r_yValid && y_ready;
    assign w_scanMode = (mode == MODE_SINGLE) || (mode == MODE_CONT);
    assign w_scanReq  = w_scanMode && start;

    // One finder serves both lookups: in IDLE it scans the live mask from
    // bit 0 for the first channel, in SCAN it walks the latched mask
    // upward from the channel currently presented.
    assign w_findMask = (r_state == SCAN) ? r_mask : en_mask;
    assign w_findIncl = (r_state == IDLE);

    scan_next_ch #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_finder (
        .i_mask (w_findMask),
        .i_cur  (r_yCh),
        .i_incl (w_findIncl),
        .o_ch   (w_findCh),
        .o_wrap (w_findWrap),
        .o_none (w_findNone)
    );

    assign w_loadCh   = ((r_state == SCAN) || w_scanReq) ? w_findCh : sel;
    assign w_loadData = pickData(din, w_loadCh);

    // Next-state and output-register logic. Scan ends either on the accept
    // of the last enabled channel (single) or on the first accept after a
    // stop was seen, including a stop arriving on the accept cycle itself.
    always_comb begin
        w_stateNxt  = r_state;
        w_yNxt      = r_y;
        w_yChNxt    = r_yCh;
        w_yValidNxt = r_yValid;
        w_doneNxt   = 1'b0;
        w_maskNxt   = r_mask;
        w_contNxt   = r_cont;
        w_stopNxt   = r_stop;

        case (r_state)
            IDLE: begin
                if (w_slotFree) begin
                    if (w_scanReq) begin
                        w_maskNxt = en_mask;
                        w_contNxt = (mode == MODE_CONT);
                        w_stopNxt = 1'b0;
                        if (w_findNone) begin
                            w_yValidNxt = 1'b0;
                            w_doneNxt   = 1'b1;
                        end else begin
                            w_yNxt      = w_loadData;
                            w_yChNxt    = w_loadCh;
                            w_yValidNxt = 1'b1;
                            w_stateNxt  = SCAN;
                        end
                    end else if (w_scanMode) begin
                        w_yValidNxt = 1'b0;
                    end else begin
                        w_yNxt      = w_loadData;
                        w_yChNxt    = w_loadCh;
                        w_yValidNxt = 1'b1;
                    end
                end
            end
            SCAN: begin
                w_stopNxt = r_stop || stop;
                if (w_accept) begin
                    if ((!r_cont && w_findWrap) || (r_cont && (r_stop || stop))) begin
                        w_yValidNxt = 1'b0;
                        w_doneNxt   = 1'b1;
                        w_stopNxt   = 1'b0;
                        w_stateNxt  = IDLE;
                    end else begin
                        w_yNxt   = w_loadData;
                        w_yChNxt = w_loadCh;
                    end
                end
            end
            default: begin
                w_stateNxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-scan
    // simply drops everything without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_y      <= '0;
            r_yCh    <= '0;
            r_yValid <= 1'b0;
            r_done   <= 1'b0;
            r_mask   <= '0;
            r_cont   <= 1'b0;
            r_stop   <= 1'b0;
        end else begin
            r_state  <= w_stateNxt;
            r_y      <= w_yNxt;
            r_yCh    <= w_yChNxt;
            r_yValid <= w_yValidNxt;
            r_done   <= w_doneNxt;
            r_mask   <= w_maskNxt;
            r_cont   <= w_contNxt;
            r_stop   <= w_stopNxt;
        end
    end

    assign y       = r_y;
    assign y_ch    = r_yCh;
    assign y_valid = r_yValid;
    assign busy    = (r_state == SCAN);
    assign done    = r_done;

endmodule : scan_mux

// File: doc/scan_mux.md
# scan_mux

Registered, parametrised N-channel multi-bit multiplexer with valid/ready output and a built-in channel sequencer. It replaces the fixed 8:1 single-bit mux in the data-select path. It supports manual select and the scanning pattern the team previously generated by hand in the bench, a free-running select counter, either once over a channel mask or continuously. It sits between a bank of parallel sources and a single downstream consumer that may stall.

## Interface
- `WIDTH`, 8, bits per channel
- `CHANNELS`, 8, number of input channels (≥2)
- `SEL_W`, `$clog2(CHANNELS)`, select/channel-index width (derived, not overridden)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `mode` in 2: 00 manual, 01 single scan, 10 continuous scan, 11 treated as manual
- `sel` in SEL_W: channel index, manual mode
- `din` in CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH]
- `en_mask` in CHANNELS: channels included in a scan, bit i = channel i
- `start` in 1: begin scan (modes 01/10), single-cycle pulse
- `stop` in 1: end continuous scan after current channel is accepted
- `y` out WIDTH: selected data
- `y_ch` out SEL_W: channel index of `y`
- `y_valid` out 1: `y`/`y_ch` valid
- `y_ready` in 1: consumer accepts when `y_valid && y_ready` at an edge
- `busy` out 1: scan in progress
- `done` out 1: one-cycle pulse at end of a scan

## Operation
- States: IDLE, SCAN. Output slot is "free" when `!y_valid || y_ready`.
- **Manual mode in IDLE:** on each edge with slot free, load `y` = channel `sel`, `y_ch` = `sel`, `y_valid` = 1. If `sel ≥ CHANNELS`, then `y` = 0 and `y_ch` = `sel`. `busy` stays 0.
- **Scan start:** in IDLE, `mode` 01/10, `start` = 1, slot free.
  - Latch `mode` and `en_mask`.
  - If the mask is nonzero, load the lowest enabled channel, set `y_valid` = 1, `busy` = 1, and go to SCAN.
  - If the mask is zero, stay in IDLE, pulse `done` the next cycle, and produce no output.
- **SCAN:** on each accept, load the next higher enabled channel at the same edge, with no bubble.
  - After the last enabled channel is accepted in single mode, or when `stop` was seen in continuous mode, clear `y_valid` and `busy`, pulse `done`, and go to IDLE.
  - In continuous mode, the last enabled channel wraps to the lowest enabled channel.
- `stop` is sticky within a scan: if asserted on any cycle in SCAN, the next accept ends the scan. It is ignored in IDLE.
- `start` is ignored while `busy` or in manual mode. `mode`, `en_mask` and `sel` changes are ignored while `busy`.
- `din` is sampled only at the edge a channel is loaded. `y` is held stable while `y_valid && !y_ready`.

## Timing
- Reset values: `y` = 0, `y_ch` = 0, `y_valid` = 0, `busy` = 0, `done` = 0, state IDLE, latched mask = 0, stop flag = 0.
- `rst` mid-scan aborts immediately with no `done` pulse.
- Manual latency: `sel`/`din` at edge k give `y` at edge k (visible in cycle k+1). Throughput is 1 per cycle with `y_ready` held high.
- Scan latency: `start` at edge k gives the first `y_valid` in cycle k+1. With `y_ready` high, M enabled channels produce M consecutive valid cycles.
- `done` is asserted for exactly the one cycle after the final accept edge. `busy` falls on that same edge.
- If the final accept and `start` coincide, `start` is ignored because the block is still busy at that edge.

## Structure
- Shared package `scan_mux_pkg`: mode constants (`MODE_MANUAL`, `MODE_SINGLE`, `MODE_CONT`) and a state enum (IDLE, SCAN).
- One sub-module, `scan_next_ch`: a combinational finder for the lowest set mask bit strictly above a given index, plus a wrap/none flag. It is reused for both the first-channel and next-channel lookups.

## Test plan
- **Manual sweep:** `WIDTH`=8, `CHANNELS`=8, `din` channel i = 8'h10+i, `sel` incrementing 0..7 per cycle, `y_ready`=1 → `y` = 10..17 each following cycle, with `y_ch` matching `sel`.
- **Single scan:** `en_mask`=8'b1010_0101, `start` pulse → `y_ch` sequence 0,2,5,7, then `done` for one cycle, with `busy` high for 4 cycles.
- **Backpressure:** as in the single-scan case but with `y_ready` low for 3 cycles on channel 2 → `y`/`y_ch` held at channel 2 for 4 cycles, no channel skipped, and `done` delayed by 3.
- **Continuous + stop:** `en_mask`=8'b0000_0110 gives 1,2,1,2,1. Asserting `stop` while channel 1 is presented → that channel is the final one, followed by `done`.
- **Zero mask / reset:** `start` with `en_mask`=0 → `done` the next cycle and `y_valid` never set. `rst` during a scan → all outputs 0 on the next cycle, with no `done` pulse.
- **Non-power-of-2:** `CHANNELS`=5 with `sel`=6 → `y`=0, `y_ch`=6, `y_valid`=1.
